// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low seven-segment bus, filters glitches, decodes each
// digit back to BCD and hands complete frames off over a valid/ready interface.
module seg7_scan_decoder #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   dig_n,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    output logic                    timeout
);

    localparam int unsigned SW = 7 + NUM_DIGITS;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0]    STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        IDLE,
        COLLECT
    } state_e;

    // Returns {err, nibble}; any non-decimal pattern (blank included) maps to F.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = 5'h00;
            7'b1111001: r = 5'h01;
            7'b0100100: r = 5'h02;
            7'b0110000: r = 5'h03;
            7'b0011001: r = 5'h04;
            7'b0010010: r = 5'h05;
            7'b0000010: r = 5'h06;
            7'b1111000: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0011000: r = 5'h09;
            default:    r = 5'h1F;
        endcase
        return r;
    endfunction

    logic [6:0]              seg_s1_q, seg_s2_q;
    logic [NUM_DIGITS-1:0]   dig_s1_q, dig_s2_q;
    logic [SW-1:0]           sample_prev_q;
    logic [7:0]              stab_cnt_q, stab_cnt_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [4*NUM_DIGITS-1:0] buf_bcd_q, buf_bcd_d;
    logic [NUM_DIGITS-1:0]   buf_err_q, buf_err_d;
    state_e                  state_q, state_d;
    logic [TW-1:0]           to_cnt_q, to_cnt_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    timeout_q, timeout_d;

    logic [SW-1:0]           sample;
    logic [3:0]              low_cnt;
    logic                    selected;
    logic                    stable_hit;
    logic [NUM_DIGITS-1:0]   new_bits;
    logic [NUM_DIGITS-1:0]   mask_acc;
    logic                    capture;
    logic                    frame_done;
    logic [4:0]              dec;

    always_comb begin
        sample  = {seg_s2_q, dig_s2_q};
        low_cnt = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            low_cnt = low_cnt + {3'b000, ~dig_s2_q[i]};
        end
        selected = (low_cnt == 4'd1);

        if (!selected) begin
            stab_cnt_d = '0;
        end else if (sample != sample_prev_q) begin
            stab_cnt_d = 8'd1;
        end else if (stab_cnt_q != STABLE_MAX) begin
            stab_cnt_d = stab_cnt_q + 8'd1;
        end else begin
            stab_cnt_d = stab_cnt_q;
        end

        // Saturation keeps a held digit from firing again until the bus changes.
        stable_hit = selected && (stab_cnt_d == STABLE_MAX) && (stab_cnt_q != STABLE_MAX);
        new_bits   = stable_hit ? (~dig_s2_q & ~mask_q) : '0;
        capture    = |new_bits;
        mask_acc   = mask_q | new_bits;
        dec        = decode_seg(seg_s2_q);

        buf_bcd_d = buf_bcd_q;
        buf_err_d = buf_err_q;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (new_bits[i]) begin
                buf_bcd_d[4*i +: 4] = dec[3:0];
                buf_err_d[i]        = dec[4];
            end
        end

        state_d    = state_q;
        mask_d     = mask_q;
        to_cnt_d   = to_cnt_q;
        timeout_d  = 1'b0;
        frame_done = 1'b0;
        if (capture) begin
            to_cnt_d = '0;
            if (&mask_acc) begin
                frame_done = 1'b1;
                mask_d     = '0;
                state_d    = IDLE;
            end else begin
                mask_d  = mask_acc;
                state_d = COLLECT;
            end
        end else if (state_q == COLLECT) begin
            if (to_cnt_q == TO_LAST) begin
                timeout_d = 1'b1;
                mask_d    = '0;
                to_cnt_d  = '0;
                state_d   = IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end

        bcd_d     = bcd_q;
        err_d     = err_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        // frame_done is combinational, so load from the next-state buffer that
        // already contains the digit captured on this edge.
        if (frame_done) begin
            if (!valid_q || out_ready) begin
                bcd_d   = buf_bcd_d;
                err_d   = buf_err_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q      <= '1;
            seg_s2_q      <= '1;
            dig_s1_q      <= '1;
            dig_s2_q      <= '1;
            sample_prev_q <= '1;
            stab_cnt_q    <= '0;
            mask_q        <= '0;
            buf_bcd_q     <= '0;
            buf_err_q     <= '0;
            state_q       <= IDLE;
            to_cnt_q      <= '0;
            bcd_q         <= '0;
            err_q         <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            seg_s1_q      <= seg_n;
            seg_s2_q      <= seg_s1_q;
            dig_s1_q      <= dig_n;
            dig_s2_q      <= dig_s1_q;
            sample_prev_q <= sample;
            stab_cnt_q    <= stab_cnt_d;
            mask_q        <= mask_d;
            buf_bcd_q     <= buf_bcd_d;
            buf_err_q     <= buf_err_d;
            state_q       <= state_d;
            to_cnt_q      <= to_cnt_d;
            bcd_q         <= bcd_d;
            err_q         <= err_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    assign bcd       = bcd_q;
    assign digit_err = err_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus pushes expected frames, a negedge
// monitor pops and compares each frame the DUT hands off.
module tb_seg7_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;
    localparam int TO = 1024;

    typedef logic [6:0]      pats_t [ND];
    typedef logic [5*ND-1:0] frame_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [6:0]      seg_n = '1;
    logic [ND-1:0]   dig_n = '1;
    logic [4*ND-1:0] bcd;
    logic [ND-1:0]   digit_err;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            overrun;
    logic            timeout;

    always #5 clk = ~clk;

    seg7_scan_decoder #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (SC),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seg_n    (seg_n),
        .dig_n    (dig_n),
        .bcd      (bcd),
        .digit_err(digit_err),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun),
        .timeout  (timeout)
    );

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0011000};

    frame_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     to_seen  = 0;

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int d = 0; d < 10; d++) begin
            if (seg_tab[d] == s) return {1'b0, 4'(d)};
        end
        return 5'h1F;
    endfunction

    function automatic frame_t model_frame(input pats_t p);
        logic [4*ND-1:0] b;
        logic [ND-1:0]   e;
        logic [4:0]      r;
        for (int i = 0; i < ND; i++) begin
            r          = ref_decode(p[i]);
            b[4*i +: 4] = r[3:0];
            e[i]       = r[4];
        end
        return {e, b};
    endfunction

    function automatic pats_t hex_pats(input logic [15:0] h);
        pats_t p;
        for (int i = 0; i < ND; i++) p[i] = seg_tab[h[4*i +: 4]];
        return p;
    endfunction

    function automatic logic [6:0] other_pat(input logic [6:0] x);
        logic [6:0] g;
        g = 7'($urandom_range(127));
        while (g == x) g = 7'($urandom_range(127));
        return g;
    endfunction

    function automatic logic [6:0] illegal_pat();
        logic [6:0] g;
        logic [4:0] r;
        g = 7'($urandom_range(127));
        r = ref_decode(g);
        while (!r[4]) begin
            g = 7'($urandom_range(127));
            r = ref_decode(g);
        end
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (timeout) to_seen++;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame actual=%h required=none", {digit_err, bcd});
                end else begin
                    frame_t e;
                    e = exp_q.pop_front();
                    if ({digit_err, bcd} !== e) begin
                        n_fail++;
                        $display("FAIL frame actual err=%b bcd=%h required err=%b bcd=%h",
                                 digit_err, bcd, e[5*ND-1:4*ND], e[4*ND-1:0]);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input int d, input logic [6:0] s, input int n);
        dig_n = ~(ND'(1) << d);
        seg_n = s;
        step(n);
    endtask

    task automatic idle(input int n);
        dig_n = '1;
        seg_n = '1;
        step(n);
    endtask

    task automatic send_frame(input pats_t p, input bit push);
        if (push) exp_q.push_back(model_frame(p));
        for (int i = ND - 1; i >= 0; i--) show(i, p[i], 8);
        idle(2);
    endtask

    task automatic random_frame();
        pats_t p;
        int    ord [ND];
        int    j, t;
        for (int i = 0; i < ND; i++) begin
            ord[i] = i;
            p[i]   = ($urandom_range(7) == 0) ? illegal_pat() : seg_tab[$urandom_range(9)];
        end
        for (int i = ND - 1; i > 0; i--) begin
            j      = $urandom_range(i);
            t      = ord[i];
            ord[i] = ord[j];
            ord[j] = t;
        end
        exp_q.push_back(model_frame(p));
        for (int k = 0; k < ND; k++) begin
            if (k == ND - 1 && $urandom_range(1) == 1)
                show(ord[0], other_pat(p[ord[0]]), 8);
            if ($urandom_range(3) == 0)
                show(ord[k], other_pat(p[ord[k]]), SC - 1);
            show(ord[k], p[ord[k]], $urandom_range(10, SC));
        end
        idle(2);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            step(1);
            guard++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        pats_t p;
        int    to0;

        rst_n = 1'b0;
        step(3);
        check("rst_bcd", bcd, 0);
        check("rst_err", digit_err, 0);
        check("rst_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        step(2);

        out_ready = 1'b1;
        send_frame(hex_pats(16'h1234), 1'b1);

        // Glitch on digit 2 shorter than the filter window must not be captured.
        exp_q.push_back(model_frame(hex_pats(16'h9061)));
        show(3, seg_tab[9], 8);
        show(2, seg_tab[8], SC - 1);
        show(2, seg_tab[0], 8);
        show(1, seg_tab[6], 8);
        show(0, seg_tab[1], 8);
        idle(2);

        p    = hex_pats(16'h5555);
        p[2] = 7'b1111111;
        send_frame(p, 1'b1);
        check("illegal_bcd", bcd, 16'h5F55);
        check("illegal_err", digit_err, 4'b0100);

        for (int n = 0; n < 16; n++) random_frame();
        drain();
        check("overrun_idle", overrun, 0);

        out_ready = 1'b0;
        send_frame(hex_pats(16'h1234), 1'b1);
        send_frame(hex_pats(16'h5678), 1'b0);
        check("ovr_valid", out_valid, 1);
        check("ovr_bcd", bcd, 16'h1234);
        check("ovr_flag", overrun, 1);
        out_ready = 1'b1;
        step(1);
        check("ovr_valid_drop", out_valid, 0);
        check("ovr_sticky", overrun, 1);

        to0 = to_seen;
        show(0, seg_tab[3], 8);
        show(1, seg_tab[4], 8);
        idle(TO + 20);
        check("timeout_pulses", to_seen - to0, 1);
        send_frame(hex_pats(16'h0987), 1'b1);

        show(0, seg_tab[6], 8);
        show(1, seg_tab[6], 8);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_bcd", bcd, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_overrun", overrun, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_frame(hex_pats(16'h2580), 1'b1);

        out_ready = 1'b0;
        send_frame(hex_pats(16'h4321), 1'b0);
        check("pend_valid", out_valid, 1);
        check("pend_bcd", bcd, 16'h4321);
        #2 rst_n = 1'b0;
        #1;
        check("vrst_bcd", bcd, 0);
        check("vrst_err", digit_err, 0);
        check("vrst_valid", out_valid, 0);
        idle(2);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(2);
        send_frame(hex_pats(16'h7096), 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the seven-segment display interface: snoops a multiplexed, active-low segment/digit-select bus and recovers the BCD digits being shown.
- Filters glitches on the bus and decodes each digit's segment pattern back to BCD.
- Assembles a full frame of NUM_DIGITS digits and hands it off over a valid/ready interface.
- Used for display loopback checking and for reading BCD results from display-driving blocks.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits per frame (1..8).
- STABLE_CYCLES, 4, number of consecutive identical synchronized samples required before a digit is captured (2..255).
- TIMEOUT_CYCLES, 1024, number of idle cycles after which a partially collected frame is discarded (≥ 2·STABLE_CYCLES).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- seg_n  in  7  segment lines, active-low; bit0=a … bit6=g.
- dig_n  in  NUM_DIGITS  digit selects, active-low; exactly one low selects a digit, bit0 = least significant digit.
- bcd  out  4*NUM_DIGITS  captured frame; nibble i belongs to digit i.
- digit_err  out  NUM_DIGITS  bit i set when digit i held a non-decimal pattern.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts the frame.
- overrun  out  1  sticky flag: a completed frame was dropped.
- timeout  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset (asynchronous, immediate on rst_n low): bcd=0, digit_err=0, out_valid=0, overrun=0, timeout=0, synchronizers=all ones, state=IDLE, captured mask=0, counters=0. A reset in mid-frame discards the partial frame.
- Synchronization: seg_n and dig_n each pass through a 2-flop synchronizer. All further logic uses the synchronized values.
- Stability filter:
  - A sample is "selected" when exactly one dig_n bit is low. The low bit's position is the digit index k.
  - The stability count increments while {seg_n,dig_n} equals the previous cycle's value and the sample is selected. The count resets to 1 on any change, and to 0 when the sample is not selected.
  - When the count reaches STABLE_CYCLES, digit k is captured, provided it is not already captured in this frame. Later re-displays of an already captured digit are ignored until the frame completes or times out. The count saturates and does not re-trigger until the next change.
  - Latency: the capture edge falls STABLE_CYCLES-1 cycles after the first synchronized sample, i.e. about STABLE_CYCLES+1 edges after the pins change.
- Decode (seg_n, written g..a → nibble):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0011000→9.
  - Any other pattern, including blank 1111111 → nibble F and digit_err bit set.
- FSM:
  - IDLE: the first capture moves to COLLECT.
  - COLLECT: when the captured mask becomes all ones, go to IDLE and raise frame_done (internal, one cycle). When the timeout counter, which counts cycles since the last capture, reaches TIMEOUT_CYCLES, clear the mask, pulse timeout, and go to IDLE.
  - If the final capture and the timeout occur in the same cycle, the capture wins.
  - With NUM_DIGITS=1, every capture completes a frame directly from IDLE.
- Output handshake:
  - On frame_done, if out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: load bcd and digit_err from the frame buffer and hold out_valid=1.
  - If out_valid=1 and out_ready=0: the new frame is dropped, the outputs stay unchanged, and overrun is set. overrun clears only on reset.
  - out_valid falls on the edge where out_ready=1, unless a new frame loads in that same cycle.
  - bcd and digit_err stay stable while out_valid=1.
- Frame buffer: capture registers are separate from the output registers, so a new frame can be collected while the previous one is still pending.

Test Plan:
- NUM_DIGITS=4: drive digits 3..0 = 1,2,3,4 with the legal codes, each held for 8 cycles, with out_ready=1 → out_valid pulses with bcd=16'h1234 and digit_err=0.
- Segment glitch: a pattern held for only STABLE_CYCLES-1 cycles, then the correct pattern for 8 cycles → only the correct digit is captured.
- Illegal pattern 1111111 on digit 2, others = 5 → bcd=16'h5F55, digit_err=4'b0100.
- Hold out_ready=0 over two complete frames (1234, then 5678) → bcd remains 1234 and overrun=1. Then out_ready=1 → out_valid drops after one cycle.
- Drive only digits 0 and 1, then dig_n=all ones for TIMEOUT_CYCLES → one timeout pulse and no out_valid. A following full frame 0987 is captured correctly.
- Pulse rst_n low mid-frame and also while out_valid=1 → all outputs return to zero immediately. The next full frame is captured normally.
